vmask_reduce_seq: RTL and testbench

Multi-cycle vector mask reduction unit for the SIMD execute stage. It implements vcpop.m (population count of active mask bits) and vfirst.m (index of the first active set bit) over a full VLEN-bit mask register. The mask is processed CHUNK bits per cycle with a valid/ready handshake. Unlike the single-cycle 64-bit counter, it honours vl, generalises VLEN and the datapath width, supports early termination for vfirst, and accepts flushes. The scalar result is written back as an XLEN value.

---
 rtl/vmask_reduce_seq_pkg.sv | 28 ++
 rtl/vmask_reduce_seq_if.sv | 42 ++++
 rtl/vmask_reduce_seq_chunk_scan.sv | 60 ++++++
 rtl/vmask_reduce_seq.sv | 183 ++++++++++++++++++
 tb/tb_vmask_reduce_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vmask_reduce_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmask_reduce_seq_pkg
// Description : Shared types and defaults for the sequential vector mask
//               reduction unit (vcpop.m / vfirst.m).
// Revision    : 1.0 - initial release
// ============================================================================
package vmask_reduce_seq_pkg;

    // Reduction operation selected per request
    typedef enum logic [0:0] {
        VMASK_CPOP  = 1'b0,
        VMASK_FIRST = 1'b1
    } vmask_op_t;

    // Control states of the reduction sequencer
    typedef enum logic [1:0] {
        VM_IDLE = 2'd0,
        VM_BUSY = 2'd1,
        VM_DONE = 2'd2
    } vmask_state_t;

    localparam int VMASK_VLEN  = 128;
    localparam int VMASK_CHUNK = 32;
    localparam int VMASK_XLEN  = 64;

endpackage : vmask_reduce_seq_pkg
`default_nettype wire

// File: rtl/vmask_reduce_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : vmask_reduce_seq_if
// Description : Request / response bundle of the mask reduction unit. The
//               master is the issuing pipeline, the slave is the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface vmask_reduce_seq_if
    import vmask_reduce_seq_pkg::*;
#(
    parameter int VLEN = VMASK_VLEN,
    parameter int XLEN = VMASK_XLEN
);
    localparam int VLW = $clog2(VLEN) + 1;

    // request side
    logic            valid;
    logic            ready;
    vmask_op_t       op;
    logic [VLW-1:0]  vl;
    logic [VLEN-1:0] data_vs2;
    logic [VLEN-1:0] data_vm;
    logic            use_mask;
    logic            kill;

    // response side
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] result;

    modport master (
        output valid, op, vl, data_vs2, data_vm, use_mask, kill, res_ready,
        input  ready, res_valid, result
    );

    modport slave (
        input  valid, op, vl, data_vs2, data_vm, use_mask, kill, res_ready,
        output ready, res_valid, result
    );

endinterface : vmask_reduce_seq_if
`default_nettype wire

// File: rtl/vmask_reduce_seq_chunk_scan.sv
`default_nettype none
// ============================================================================
// Module      : vmask_chunk_scan
// Description : Combinational scan of one CHUNK-wide slice of the mask:
//               active-bit popcount plus lowest active element index.
// Revision    : 1.0 - initial release
// ============================================================================
module vmask_chunk_scan
    import vmask_reduce_seq_pkg::*;
#(
    parameter int VLEN  = VMASK_VLEN,
    parameter int CHUNK = VMASK_CHUNK,
    localparam int VLW  = $clog2(VLEN) + 1,
    localparam int IW   = (VLEN > 1) ? $clog2(VLEN) : 1,
    localparam int CW   = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] vs2_bits,
    input  logic [CHUNK-1:0] vm_bits,
    input  logic             use_mask,
    input  logic [VLW-1:0]   base,
    input  logic [VLW-1:0]   vl,
    output logic [CW-1:0]    pop,
    output logic             hit,
    output logic [IW-1:0]    hit_idx
);
    localparam int OW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    logic [CHUNK-1:0] active;
    logic [OW-1:0]    offset;

    // An element counts only if it is below vl, set in vs2 and enabled by v0
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_active
        assign active[gi] = vs2_bits[gi]
                          && (!use_mask || vm_bits[gi])
                          && ((base + VLW'(gi)) < vl);
    end

    // Population count of the active elements in this slice
    always_comb begin
        pop = '0;
        for (int j = 0; j < CHUNK; j++) begin
            pop = pop + CW'(active[j]);
        end
    end

    // Lowest active element: scan downwards so the last write wins
    always_comb begin
        offset = '0;
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (active[j]) begin
                offset = OW'(j);
            end
        end
    end

    assign hit     = |active;
    assign hit_idx = base[IW-1:0] + IW'(offset);

endmodule : vmask_chunk_scan
`default_nettype wire

// File: rtl/vmask_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : vmask_reduce_seq
// Description : Multi-cycle vcpop.m / vfirst.m unit. Scans a VLEN-bit mask
//               CHUNK bits per cycle, honours vl and v0 masking, exits early
//               for vfirst and returns an XLEN scalar over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module vmask_reduce_seq
    import vmask_reduce_seq_pkg::*;
#(
    parameter int VLEN  = VMASK_VLEN,
    parameter int CHUNK = VMASK_CHUNK,
    parameter int XLEN  = VMASK_XLEN
) (
    input  logic              clk,
    input  logic              rstn,
    vmask_reduce_seq_if.slave bus
);
    localparam int VLW   = $clog2(VLEN) + 1;
    localparam int IW    = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int CW    = $clog2(CHUNK) + 1;
    localparam int NCH   = VLEN / CHUNK;
    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LOG2C = $clog2(CHUNK);

    vmask_state_t    state;
    vmask_state_t    state_nxt;

    // latched request
    vmask_op_t       op_q;
    logic [VLEN-1:0] vs2_q;
    logic [VLEN-1:0] vm_q;
    logic            use_mask_q;
    logic [VLW-1:0]  vl_q;

    // sequencing and accumulators
    logic [PW-1:0]   ptr;
    logic [VLW-1:0]  count;
    logic            hit_found;
    logic [IW-1:0]   hit_idx_q;
    logic            res_valid_q;
    logic [XLEN-1:0] result_q;

    // scan datapath
    logic [CHUNK-1:0] vs2_chunks [NCH];
    logic [CHUNK-1:0] vm_chunks  [NCH];
    logic [VLW-1:0]   chunk_base;
    logic [PW-1:0]    last_ptr;
    logic [CW-1:0]    scan_pop;
    logic             scan_hit;
    logic [IW-1:0]    scan_idx;
    logic             is_last;
    logic             scan_finish;
    logic [VLW-1:0]   vl_clamped;

    for (genvar gc = 0; gc < NCH; gc++) begin : g_split
        assign vs2_chunks[gc] = vs2_q[gc*CHUNK +: CHUNK];
        assign vm_chunks[gc]  = vm_q[gc*CHUNK +: CHUNK];
    end

    assign chunk_base = VLW'(ptr) << LOG2C;

    // Last chunk that can hold an element below vl; vl=0 still scans chunk 0
    assign last_ptr = (vl_q == '0) ? '0 : PW'((vl_q - VLW'(1)) >> LOG2C);
    assign is_last  = (ptr == last_ptr);

    // vfirst stops on the first chunk with a hit; earlier chunks had none
    assign scan_finish = is_last || ((op_q == VMASK_FIRST) && scan_hit);

    assign vl_clamped = (bus.vl > VLW'(VLEN)) ? VLW'(VLEN) : bus.vl;

    vmask_chunk_scan #(
        .VLEN  (VLEN),
        .CHUNK (CHUNK)
    ) u_scan (
        .vs2_bits (vs2_chunks[ptr]),
        .vm_bits  (vm_chunks[ptr]),
        .use_mask (use_mask_q),
        .base     (chunk_base),
        .vl       (vl_q),
        .pop      (scan_pop),
        .hit      (scan_hit),
        .hit_idx  (scan_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= VM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a flush overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            VM_IDLE: if (bus.valid)                       state_nxt = VM_BUSY;
            VM_BUSY: if (scan_finish)                     state_nxt = VM_DONE;
            VM_DONE: if (res_valid_q && bus.res_ready)    state_nxt = VM_IDLE;
            default:                                      state_nxt = VM_IDLE;
        endcase
        if (bus.kill) begin
            state_nxt = VM_IDLE;
        end
    end

    // Capture the request operands on acceptance; contents are don't-care otherwise
    always_ff @(posedge clk) begin
        if (state == VM_IDLE && bus.valid) begin
            op_q       <= bus.op;
            vs2_q      <= bus.data_vs2;
            vm_q       <= bus.data_vm;
            use_mask_q <= bus.use_mask;
            vl_q       <= vl_clamped;
        end
    end

    // Chunk pointer, accumulators and the registered response
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr         <= '0;
            count       <= '0;
            hit_found   <= 1'b0;
            hit_idx_q   <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (bus.kill) begin
            ptr         <= '0;
            count       <= '0;
            hit_found   <= 1'b0;
            hit_idx_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                VM_IDLE: begin
                    if (bus.valid) begin
                        ptr       <= '0;
                        count     <= '0;
                        hit_found <= 1'b0;
                        hit_idx_q <= '0;
                    end
                end
                VM_BUSY: begin
                    if (op_q == VMASK_CPOP) begin
                        count <= count + VLW'(scan_pop);
                    end
                    if (op_q == VMASK_FIRST && !hit_found && scan_hit) begin
                        hit_found <= 1'b1;
                        hit_idx_q <= scan_idx;
                    end
                    if (!scan_finish) begin
                        ptr <= ptr + PW'(1);
                    end
                end
                VM_DONE: begin
                    // First DONE cycle registers the scalar; then hold until taken
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                        if (op_q == VMASK_FIRST) begin
                            result_q <= hit_found ? XLEN'(hit_idx_q) : '1;
                        end else begin
                            result_q <= XLEN'(count);
                        end
                    end else if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = (state == VM_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;

endmodule : vmask_reduce_seq
`default_nettype wire

// File: tb/tb_vmask_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmask_reduce_seq
// Description : Self-checking bench for vmask_reduce_seq with directed cases
//               and randomized requests against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmask_reduce_seq;
    import vmask_reduce_seq_pkg::*;

    localparam int VLEN  = 128;
    localparam int CHUNK = 32;
    localparam int XLEN  = 64;
    localparam int VLW   = $clog2(VLEN) + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vmask_reduce_seq_if #(.VLEN(VLEN), .XLEN(XLEN)) bus ();

    vmask_reduce_seq #(
        .VLEN  (VLEN),
        .CHUNK (CHUNK),
        .XLEN  (XLEN)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the active elements directly from the rules
    task automatic model(input vmask_op_t op, input logic [VLEN-1:0] vs2,
                         input logic [VLEN-1:0] vm, input logic um, input int vl,
                         output logic [63:0] res, output int n);
        int eff;
        int cnt;
        int first;
        eff   = (vl > VLEN) ? VLEN : vl;
        cnt   = 0;
        first = -1;
        for (int i = 0; i < eff; i++) begin
            if (vs2[i] && (!um || vm[i])) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        n = (eff == 0) ? 1 : (eff + CHUNK - 1) / CHUNK;
        if (op == VMASK_CPOP) begin
            res = 64'(cnt);
        end else begin
            res = (first < 0) ? '1 : 64'(first);
            if (first >= 0) n = first / CHUNK + 1;
        end
    endtask

    task automatic drive(input vmask_op_t op, input logic [VLEN-1:0] vs2,
                         input logic [VLEN-1:0] vm, input logic um, input int vl);
        bus.op       = op;
        bus.data_vs2 = vs2;
        bus.data_vm  = vm;
        bus.use_mask = um;
        bus.vl       = VLW'(vl);
        bus.valid    = 1'b1;
    endtask

    // Present a request at a negedge, hold valid until accepted
    task automatic send(input vmask_op_t op, input logic [VLEN-1:0] vs2,
                        input logic [VLEN-1:0] vm, input logic um, input int vl);
        int g;
        drive(op, vs2, vm, um, vl);
        g = 0;
        while (!bus.ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    // Count edges from acceptance until the result is presented
    task automatic wait_result(input string tag, input logic [63:0] exp, input int n);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!bus.res_valid && cyc < 200);
        check({tag, "_lat"}, 64'(cyc), 64'(n + 1));
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_rdy"}, 64'(bus.ready), 64'd0);
    endtask

    task automatic consume(input string tag, input logic [63:0] exp, input int stall);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_v"}, 64'(bus.res_valid), 64'd1);
            check({tag, "_hold_r"}, bus.result, exp);
            check({tag, "_hold_rdy"}, 64'(bus.ready), 64'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_drop"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_idle"}, 64'(bus.ready), 64'd1);
    endtask

    task automatic run(input string tag, input vmask_op_t op, input logic [VLEN-1:0] vs2,
                       input logic [VLEN-1:0] vm, input logic um, input int vl, input int stall);
        logic [63:0] exp;
        int          n;
        model(op, vs2, vm, um, vl, exp, n);
        send(op, vs2, vm, um, vl);
        wait_result(tag, exp, n);
        consume(tag, exp, stall);
    endtask

    function automatic logic [VLEN-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [VLEN-1:0] ones;
        logic [VLEN-1:0] alt;
        logic [VLEN-1:0] b40;
        logic [VLEN-1:0] v2;
        logic [VLEN-1:0] m2;
        logic [63:0]     exp;
        int              n;
        vmask_op_t       op;

        ones = '1;
        alt  = {(VLEN/2){2'b01}};
        b40  = '0;
        b40[40]  = 1'b1;
        b40[100] = 1'b1;

        bus.valid     = 1'b0;
        bus.op        = VMASK_CPOP;
        bus.vl        = '0;
        bus.data_vs2  = '0;
        bus.data_vm   = '0;
        bus.use_mask  = 1'b0;
        bus.kill      = 1'b0;
        bus.res_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_valid", 64'(bus.res_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);

        // directed cases
        run("cpop_full",  VMASK_CPOP,  ones, '0,   1'b0, 128, 0);
        run("cpop_mask",  VMASK_CPOP,  ones, alt,  1'b1, 70,  1);
        run("first_40",   VMASK_FIRST, b40,  '0,   1'b0, 128, 0);
        run("first_vl40", VMASK_FIRST, b40,  '0,   1'b0, 40,  0);
        run("first_none", VMASK_FIRST, '0,   '0,   1'b0, 128, 0);
        run("cpop_vl0",   VMASK_CPOP,  ones, '0,   1'b0, 0,   0);
        run("first_vl0",  VMASK_FIRST, ones, '0,   1'b0, 0,   0);
        run("cpop_clamp", VMASK_CPOP,  ones, '0,   1'b0, 200, 0);

        // stalled result with a competing request, then back-to-back issue
        model(VMASK_CPOP, ones, alt, 1'b1, 128, exp, n);
        send(VMASK_CPOP, ones, alt, 1'b1, 128);
        wait_result("stall", exp, n);
        drive(VMASK_FIRST, b40, '0, 1'b0, 128);
        consume("stall", exp, 3);
        model(VMASK_FIRST, b40, '0, 1'b0, 128, exp, n);
        send(VMASK_FIRST, b40, '0, 1'b0, 128);
        wait_result("b2b", exp, n);
        consume("b2b", exp, 0);

        // flush in the second BUSY cycle while a new request is offered
        send(VMASK_CPOP, ones, '0, 1'b0, 128);
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        drive(VMASK_CPOP, ones, '0, 1'b0, 64);
        @(posedge clk);
        @(negedge clk);
        bus.kill  = 1'b0;
        bus.valid = 1'b0;
        check("kill_valid", 64'(bus.res_valid), 64'd0);
        check("kill_idle", 64'(bus.ready), 64'd1);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            check("kill_quiet", 64'(bus.res_valid), 64'd0);
        end
        run("after_kill", VMASK_CPOP, ones, alt, 1'b1, 100, 0);

        // reset in the middle of a scan
        send(VMASK_CPOP, ones, '0, 1'b0, 128);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("mrst_idle", 64'(bus.ready), 64'd1);
        check("mrst_valid", 64'(bus.res_valid), 64'd0);
        check("mrst_result", bus.result, 64'd0);
        run("after_rst", VMASK_CPOP, ones, '0, 1'b0, 97, 0);

        // randomized requests
        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 1) == 1) ? VMASK_FIRST : VMASK_CPOP;
            v2 = rnd128();
            if (op == VMASK_FIRST) begin
                v2 = v2 & rnd128() & rnd128() & rnd128();
                if ($urandom_range(0, 3) == 0) v2 = '0;
            end
            m2 = rnd128();
            run("rand", op, v2, m2, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 140)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vmask_reduce_seq
`default_nettype wire
